// File: rtl/axi2mem_rd_ctrl_if.sv
// Interface bundle for axi2mem_rd_ctrl: AR channel, memory read port and R channel.
// slave = controller view, master = environment view.
interface axi2mem_rd_ctrl_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  ar_valid_i;
  logic                  ar_ready_o;
  logic [ADDR_WIDTH-1:0] ar_addr_i;
  logic [7:0]            ar_len_i;
  logic [2:0]            ar_size_i;
  logic [1:0]            ar_burst_i;
  logic [ID_WIDTH-1:0]   ar_id_i;

  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  r_valid_o;
  logic                  r_ready_i;
  logic [DATA_WIDTH-1:0] r_data_o;
  logic [1:0]            r_resp_o;
  logic                  r_last_o;
  logic [ID_WIDTH-1:0]   r_id_o;

  modport slave (
    input  ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, r_ready_i,
    output ar_ready_o, mem_req_o, mem_addr_o,
    output r_valid_o, r_data_o, r_resp_o, r_last_o, r_id_o
  );

  modport master (
    output ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, r_ready_i,
    input  ar_ready_o, mem_req_o, mem_addr_o,
    input  r_valid_o, r_data_o, r_resp_o, r_last_o, r_id_o
  );
endinterface

// File: rtl/axi2mem_rd_ctrl.sv
// AXI read burst to single-port memory controller: one beat in flight at a time.
// Optional WRAP burst support is compiled in with `define AXI2MEM_RD_CTRL_WRAP_EN;
// without it WRAP bursts behave as INCR.
module axi2mem_rd_ctrl #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  axi2mem_rd_ctrl_if.slave  bus
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ar_ready_q, ar_ready_d;
  logic                  mem_req_q, mem_req_d;
  logic                  r_valid_q, r_valid_d;
  logic                  r_last_q, r_last_d;

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  ar_err;
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
  logic [7:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] wrap_mask;
`endif

  // Reject reserved bursts (and, with WRAP compiled in, illegal WRAP lengths) at accept
  always_comb begin
    ar_err = (bus.ar_burst_i == BURST_RSVD);
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
    if ((bus.ar_burst_i == BURST_WRAP) &&
        !((bus.ar_len_i == 8'd1) || (bus.ar_len_i == 8'd3) ||
          (bus.ar_len_i == 8'd7) || (bus.ar_len_i == 8'd15))) begin
      ar_err = 1'b1;
    end
`endif
  end

  // Address of the following beat for the captured burst type
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    next_addr = addr_q + step;
    if (burst_q == BURST_FIXED) begin
      next_addr = addr_q;
    end
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
    wrap_mask = (ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q) - ADDR_WIDTH'(1);
    if (burst_q == BURST_WRAP) begin
      next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
    end
`endif
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    burst_d = burst_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
    len_d   = len_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.ar_valid_i) begin
          addr_d  = bus.ar_addr_i;
          size_d  = bus.ar_size_i;
          burst_d = bus.ar_burst_i;
          id_d    = bus.ar_id_i;
          cnt_d   = bus.ar_len_i;
          err_d   = ar_err;
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
          len_d   = bus.ar_len_i;
`endif
          if (ar_err) begin
            data_d  = '0;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          data_d  = bus.mem_rdata_i;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.r_ready_i) begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = next_addr;
            state_d = err_q ? RESP : REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ar_ready_d = (state_d == IDLE);
    mem_req_d  = (state_d == REQ);
    r_valid_d  = (state_d == RESP);
    r_last_d   = (state_d == RESP) && (cnt_d == 8'd0);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      ar_ready_q <= 1'b1;
      mem_req_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
      len_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      data_q     <= data_d;
      ar_ready_q <= ar_ready_d;
      mem_req_q  <= mem_req_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
      len_q      <= len_d;
`endif
    end
  end

  assign bus.ar_ready_o = ar_ready_q;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.r_valid_o  = r_valid_q;
  assign bus.r_data_o   = data_q;
  assign bus.r_resp_o   = {err_q, 1'b0};
  assign bus.r_last_o   = r_last_q;
  assign bus.r_id_o     = id_q;

endmodule

// File: tb/tb_axi2mem_rd_ctrl.sv
// Scoreboard bench for axi2mem_rd_ctrl: directed bursts push expected memory
// addresses and R beats; a monitor pops and compares on every handshake.
module tb_axi2mem_rd_ctrl;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;

  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_a[$];
  beat_t       exp_r[$];

  int   gnt_delay = 0;
  int   r_delay   = 0;
  int   acc_cyc   = 0;
  logic lat_pend  = 1'b0;
  int   r_hs      = 0;

  axi2mem_rd_ctrl_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi2mem_rd_ctrl #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_ok(input logic [31:0] a, input logic last, input logic [3:0] id);
    beat_t b;
    b.data = mem_word(a);
    b.resp = 2'b00;
    b.last = last;
    b.id   = id;
    exp_a.push_back(a);
    exp_r.push_back(b);
  endtask

  task automatic exp_slverr(input logic last, input logic [3:0] id);
    beat_t b;
    b.data = 64'd0;
    b.resp = 2'b10;
    b.last = last;
    b.id   = id;
    exp_r.push_back(b);
  endtask

  // Memory and R-sink responder: grant after gnt_delay, rvalid the cycle after grant
  initial begin
    logic        mfire;
    logic        rfire;
    logic [31:0] faddr;
    int          gage;
    int          rage;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 64'd0;
    bus.r_ready_i    = 1'b0;
    gage = 0;
    rage = 0;
    forever begin
      @(negedge clk_i);
      mfire = bus.mem_req_o && bus.mem_gnt_i;
      faddr = bus.mem_addr_o;
      rfire = bus.r_valid_o && bus.r_ready_i;
      @(posedge clk_i);
      #1;
      bus.mem_rvalid_i = mfire;
      bus.mem_rdata_i  = mfire ? mem_word(faddr) : 64'hDEAD_BEEF_0BAD_F00D;
      if (bus.mem_req_o) begin
        bus.mem_gnt_i = (gage >= gnt_delay);
        gage++;
      end else begin
        bus.mem_gnt_i = 1'b0;
        gage = 0;
      end
      if (rfire) rage = 0;
      if (bus.r_valid_o) begin
        bus.r_ready_i = (rage >= r_delay);
        rage++;
      end else begin
        bus.r_ready_i = 1'b0;
        rage = 0;
      end
    end
  end

  // Monitor: pops expectations on handshakes and checks stability while stalled
  initial begin
    logic        req_hold;
    logic [31:0] hold_addr;
    logic        r_hold;
    beat_t       hold_beat;
    beat_t       cur;
    req_hold = 1'b0;
    r_hold   = 1'b0;
    hold_addr = 32'd0;
    hold_beat = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        req_hold = 1'b0;
        r_hold   = 1'b0;
      end else begin
        if (bus.mem_req_o) begin
          if (req_hold) chk("mem_addr_stable", 80'(bus.mem_addr_o), 80'(hold_addr));
          if (bus.mem_gnt_i) begin
            if (exp_a.size() == 0) chk("mem_req_unexpected", 80'(bus.mem_addr_o), 80'hF_FFFF_FFFF);
            else chk("mem_addr", 80'(bus.mem_addr_o), 80'(exp_a.pop_front()));
            req_hold = 1'b0;
          end else begin
            req_hold  = 1'b1;
            hold_addr = bus.mem_addr_o;
          end
        end else if (req_hold) begin
          chk("mem_req_dropped", 80'(0), 80'(1));
          req_hold = 1'b0;
        end

        if (bus.r_valid_o) begin
          if (lat_pend) begin
            chk("first_r_latency", 80'(cyc - acc_cyc), 80'(3));
            lat_pend = 1'b0;
          end
          cur.data = bus.r_data_o;
          cur.resp = bus.r_resp_o;
          cur.last = bus.r_last_o;
          cur.id   = bus.r_id_o;
          if (r_hold) chk("r_stable", 80'(cur), 80'(hold_beat));
          if (bus.r_ready_i) begin
            if (exp_r.size() == 0) chk("r_beat_unexpected", 80'(cur), 80'hF_FFFF_FFFF);
            else chk("r_beat", 80'(cur), 80'(exp_r.pop_front()));
            r_hs++;
            r_hold = 1'b0;
          end else begin
            r_hold    = 1'b1;
            hold_beat = cur;
          end
        end else if (r_hold) begin
          chk("r_valid_dropped", 80'(0), 80'(1));
          r_hold = 1'b0;
        end
      end
    end
  end

  task automatic issue_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id,
                          input int gd, input int rd, input logic lat);
    logic acc;
    acc = 1'b0;
    gnt_delay = gd;
    r_delay   = rd;
    @(posedge clk_i);
    #1;
    bus.ar_valid_i = 1'b1;
    bus.ar_addr_i  = a;
    bus.ar_len_i   = len;
    bus.ar_size_i  = size;
    bus.ar_burst_i = burst;
    bus.ar_id_i    = id;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (bus.ar_ready_o) begin
        acc_cyc  = cyc;
        lat_pend = lat;
        acc      = 1'b1;
        break;
      end
    end
    if (!acc) chk("ar_accept_timeout", 80'(0), 80'(1));
    @(posedge clk_i);
    #1;
    bus.ar_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      #1;
      if (exp_a.size() == 0 && exp_r.size() == 0 && bus.ar_ready_o) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      $display("FAIL %s: burst timeout, got %0d addr / %0d beats pending expected 0",
               nm, exp_a.size(), exp_r.size());
      n_cmp++;
      n_err++;
      exp_a.delete();
      exp_r.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ar_ready"}, 80'(bus.ar_ready_o), 80'(1));
    chk({nm, "_mem_req"},  80'(bus.mem_req_o),  80'(0));
    chk({nm, "_mem_addr"}, 80'(bus.mem_addr_o), 80'(0));
    chk({nm, "_r_valid"},  80'(bus.r_valid_o),  80'(0));
    chk({nm, "_r_data"},   80'(bus.r_data_o),   80'(0));
    chk({nm, "_r_resp"},   80'(bus.r_resp_o),   80'(0));
    chk({nm, "_r_last"},   80'(bus.r_last_o),   80'(0));
    chk({nm, "_r_id"},     80'(bus.r_id_o),     80'(0));
  endtask

  initial begin
    logic seen;
    bus.ar_valid_i = 1'b0;
    bus.ar_addr_i  = 32'd0;
    bus.ar_len_i   = 8'd0;
    bus.ar_size_i  = 3'd0;
    bus.ar_burst_i = 2'b00;
    bus.ar_id_i    = 4'd0;

    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("reset");

    // INCR 0x1000 len3 size3, immediate grant, first beat 3 cycles after accept
    exp_ok(32'h1000, 1'b0, 4'd1);
    exp_ok(32'h1008, 1'b0, 4'd1);
    exp_ok(32'h1010, 1'b0, 4'd1);
    exp_ok(32'h1018, 1'b1, 4'd1);
    issue_ar(32'h1000, 8'd3, 3'd3, 2'b01, 4'd1, 0, 0, 1'b1);
    wait_done("incr");

    // WRAP 0x1018 len3 size3
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
    exp_ok(32'h1018, 1'b0, 4'd2);
    exp_ok(32'h1000, 1'b0, 4'd2);
    exp_ok(32'h1008, 1'b0, 4'd2);
    exp_ok(32'h1010, 1'b1, 4'd2);
`else
    exp_ok(32'h1018, 1'b0, 4'd2);
    exp_ok(32'h1020, 1'b0, 4'd2);
    exp_ok(32'h1028, 1'b0, 4'd2);
    exp_ok(32'h1030, 1'b1, 4'd2);
`endif
    issue_ar(32'h1018, 8'd3, 3'd3, 2'b10, 4'd2, 0, 0, 1'b1);
    wait_done("wrap");

    // WRAP with illegal length 2
`ifdef AXI2MEM_RD_CTRL_WRAP_EN
    exp_slverr(1'b0, 4'd4);
    exp_slverr(1'b0, 4'd4);
    exp_slverr(1'b1, 4'd4);
`else
    exp_ok(32'h2000, 1'b0, 4'd4);
    exp_ok(32'h2004, 1'b0, 4'd4);
    exp_ok(32'h2008, 1'b1, 4'd4);
`endif
    issue_ar(32'h2000, 8'd2, 3'd2, 2'b10, 4'd4, 0, 1, 1'b0);
    wait_done("wrap_len2");

    // FIXED 0x40 len2, grant stalled 5 cycles, r_ready low 4 cycles per beat
    exp_ok(32'h40, 1'b0, 4'd3);
    exp_ok(32'h40, 1'b0, 4'd3);
    exp_ok(32'h40, 1'b1, 4'd3);
    issue_ar(32'h40, 8'd2, 3'd3, 2'b00, 4'd3, 5, 4, 1'b0);
    wait_done("fixed_stall");

    // Reserved burst: no memory traffic, SLVERR beats
    exp_slverr(1'b0, 4'd5);
    exp_slverr(1'b1, 4'd5);
    issue_ar(32'h8000, 8'd1, 3'd3, 2'b11, 4'd5, 0, 0, 1'b0);
    wait_done("reserved");

    // INCR crossing the top of the address space
    exp_ok(32'hFFFF_FFF8, 1'b0, 4'd9);
    exp_ok(32'h0000_0000, 1'b1, 4'd9);
    issue_ar(32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 4'd9, 0, 0, 1'b1);
    wait_done("addr_wrap");

    // 256-beat INCR, byte size, unaligned start
    for (int i = 0; i < 256; i++) exp_ok(32'h101 + 32'(i), (i == 255), 4'd10);
    issue_ar(32'h101, 8'd255, 3'd0, 2'b01, 4'd10, 0, 0, 1'b1);
    wait_done("len255");

    // Reset asserted while beat 2 of an 8-beat INCR waits for r_ready
    for (int i = 0; i < 8; i++) exp_ok(32'h3000 + 32'(8 * i), (i == 7), 4'd6);
    r_hs = 0;
    issue_ar(32'h3000, 8'd7, 3'd3, 2'b01, 4'd6, 0, 4, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      #1;
      if (r_hs == 1 && bus.r_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reset_beat2_reached", 80'(seen), 80'(1));
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_r_valid", 80'(bus.r_valid_o), 80'(0));
    chk("rst_mem_req", 80'(bus.mem_req_o), 80'(0));
    exp_a.delete();
    exp_r.delete();
    lat_pend = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("post_reset");

    // Clean burst after reset
    exp_ok(32'h500, 1'b0, 4'd7);
    exp_ok(32'h504, 1'b1, 4'd7);
    issue_ar(32'h500, 8'd1, 3'd2, 2'b01, 4'd7, 0, 0, 1'b1);
    wait_done("after_reset");

    chk("exp_addr_left", 80'(exp_a.size()), 80'(0));
    chk("exp_beat_left", 80'(exp_r.size()), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi2mem_rd_ctrl.md
AXI2MEM_RD_CTRL -- requirements
Module: axi2mem_rd_ctrl

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, memory and R data width.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ar_valid_i  input  1  read address valid, from the AR buffer.
REQ-007 SHALL have port ar_ready_o  output  1  read address accepted.
REQ-008 SHALL have port ar_addr_i  input  ADDR_WIDTH  burst start byte address.
REQ-009 SHALL have port ar_len_i  input  8  beats minus one.
REQ-010 SHALL have port ar_size_i  input  3  log2 bytes per beat.
REQ-011 SHALL have port ar_burst_i  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-012 SHALL have port ar_id_i  input  ID_WIDTH  transaction ID.
REQ-013 SHALL have port mem_req_o  output  1  memory read request.
REQ-014 SHALL have port mem_gnt_i  input  1  memory grant for the current request.
REQ-015 SHALL have port mem_addr_o  output  ADDR_WIDTH  memory byte address.
REQ-016 SHALL have port mem_rvalid_i  input  1  memory read data valid.
REQ-017 SHALL have port mem_rdata_i  input  DATA_WIDTH  memory read data.
REQ-018 SHALL have port r_valid_o  output  1  R beat valid.
REQ-019 SHALL have port r_ready_i  input  1  R beat accepted.
REQ-020 SHALL have port r_data_o  output  DATA_WIDTH  R beat data.
REQ-021 SHALL have port r_resp_o  output  2  00 OKAY, 10 SLVERR.
REQ-022 SHALL have port r_last_o  output  1  final beat of burst.
REQ-023 SHALL have port r_id_o  output  ID_WIDTH  ID of the captured burst.

Function
REQ-024 SHALL implement FSM IDLE, REQ, WAIT, RESP; ar_ready_o=1 only in IDLE.
REQ-025 SHALL, on ar_valid_i&&ar_ready_o, capture addr/len/size/burst/id, load beat counter = len, and go to REQ next cycle (burst 11: RESP directly).
REQ-026 SHALL drive mem_req_o=1 with mem_addr_o = current beat address in REQ; hold both stable until mem_gnt_i; on grant go to WAIT.
REQ-027 SHALL keep at most one memory request outstanding; mem_req_o=0 in IDLE, WAIT, RESP.
REQ-028 SHALL, in WAIT on mem_rvalid_i, register mem_rdata_i into r_data_o and enter RESP; mem_rvalid_i outside WAIT is ignored.
REQ-029 SHALL in RESP hold r_valid_o=1 and r_data/resp/last/id stable until r_ready_i; r_last_o=1 iff beat counter is 0.
REQ-030 SHALL on R handshake with r_last_o=1 go to IDLE; otherwise decrement counter, advance address, go to REQ.
REQ-031 SHALL advance address: FIXED unchanged; INCR addr + (1<<size) modulo 2^ADDR_WIDTH; WRAP per REQ-040.
REQ-032 SHALL not split or check 4 KB boundaries; unaligned INCR start advances from the unaligned address.
REQ-033 SHALL, for burst 11, issue no memory request, return len+1 beats with r_resp_o=10, r_data_o=0, correct r_last_o.
REQ-034 SHALL produce minimum per-beat latency: AR accept cycle + REQ (gnt same cycle) + WAIT (rvalid next cycle) + RESP = 3 cycles after accept to first r_valid_o.
REQ-035 SHALL support len=255 (256 beats) without counter overflow.

Reset
REQ-036 SHALL on rst_ni=0, asynchronously and at any FSM state, enter IDLE, abandon any burst, and clear all registers.
REQ-037 SHALL reset outputs: ar_ready_o=1 after reset release (IDLE), mem_req_o=0, mem_addr_o=0, r_valid_o=0, r_data_o=0, r_resp_o=0, r_last_o=0, r_id_o=0.

Configuration
REQ-038 SHALL use macro AXI2MEM_RD_CTRL_WRAP_EN to compile WRAP support in.
REQ-039 SHALL, without the macro, treat burst 10 exactly as INCR with r_resp_o=00.
REQ-040 SHALL, with the macro, wrap within total = (len+1)<<size bytes: next = (addr & ~(total-1)) | ((addr + (1<<size)) & (total-1)); WRAP with len not in {1,3,7,15} returns SLVERR beats as in REQ-033.

Verification
REQ-041 SHALL cover INCR addr=0x1000 len=3 size=3, gnt immediate, rvalid next cycle, r_ready=1 -> mem_addr 0x1000/08/10/18, 4 beats, r_last only on 4th, first r_valid 3 cycles after accept.
REQ-042 SHALL cover WRAP (macro on) addr=0x1018 len=3 size=3 -> addresses 0x1018,0x1000,0x1008,0x1010; macro off -> 0x1018,0x1020,0x1028,0x1030.
REQ-043 SHALL cover FIXED addr=0x40 len=2 with gnt stalled 5 cycles and r_ready low 4 cycles per beat -> mem_addr 0x40 held, r_* stable during stall, 3 beats.
REQ-044 SHALL cover burst 11 len=1 id=5 -> mem_req_o never asserted, 2 beats r_resp=10, r_id=5, r_last on 2nd.
REQ-045 SHALL cover rst_ni low during RESP of beat 2 of an 8-beat INCR -> r_valid_o=0, mem_req_o=0 immediately, next AR accepted cleanly.
REQ-046 SHALL cover INCR addr=0xFFFFFFF8 len=1 size=3 -> second address 0x00000000.
